// File: rtl/serial_operand_serializer_if.sv
// serial_operand_serializer_if: upstream word handshake (operands, length, valid/ready)
interface serial_operand_serializer_if #(parameter int WIDTH = 8);
  logic in_vld;
  logic in_rdy;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [$clog2(WIDTH)-1:0] in_len_m1;
  modport master (output in_vld, in_a, in_b, in_len_m1, input in_rdy);
  modport slave (input in_vld, in_a, in_b, in_len_m1, output in_rdy);
endinterface

// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer: LSB-first operand streamer; SERIAL_TX_PREFETCH_EN adds a one-word buffer for gapless streams
module serial_operand_serializer #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst,
  serial_operand_serializer_if.slave bus,
  input  logic hold,
  output logic vld,
  output logic a,
  output logic b,
  output logic last,
  output logic busy
);
  localparam int LW = $clog2(WIDTH);
  localparam logic [LW-1:0] MAXL = LW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] sa, sb, na, nb;
  logic [LW-1:0] len, idx, in_len, nl;
  logic xfer, free, ld;
  if ((1 << LW) == WIDTH) begin : g_p2
    assign in_len = bus.in_len_m1;
  end else begin : g_cl
    assign in_len = bus.in_len_m1 > MAXL ? MAXL : bus.in_len_m1;
  end
  assign busy = state == SHIFT;
  assign free = state == IDLE || last;
  assign xfer = bus.in_vld && bus.in_rdy;
`ifdef SERIAL_TX_PREFETCH_EN
  logic fb;
  logic [WIDTH-1:0] pa, pb;
  logic [LW-1:0] pl;
  assign bus.in_rdy = !fb;
  assign na = fb ? pa : bus.in_a;
  assign nb = fb ? pb : bus.in_b;
  assign nl = fb ? pl : in_len;
  assign ld = fb || xfer;
  // buffer a word arriving while the shifter is still busy with a bit other than the last
  always_ff @(posedge clk) begin
    if (rst) fb <= 1'b0;
    else if (free) fb <= 1'b0;
    else if (xfer) begin
      fb <= 1'b1;
      pa <= bus.in_a;
      pb <= bus.in_b;
      pl <= in_len;
    end
  end
`else
  assign bus.in_rdy = !busy;
  assign na = bus.in_a;
  assign nb = bus.in_b;
  assign nl = in_len;
  assign ld = xfer;
`endif
  // shifter FSM: load when free (idle or last being consumed), otherwise present the next bit unless held
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      vld <= 1'b0;
      a <= 1'b0;
      b <= 1'b0;
      last <= 1'b0;
    end else begin
      vld <= 1'b0;
      a <= 1'b0;
      b <= 1'b0;
      last <= 1'b0;
      if (free) begin
        state <= ld ? SHIFT : IDLE;
        if (ld) begin
          sa <= na;
          sb <= nb;
          len <= nl;
          idx <= hold ? '0 : LW'(1);
          if (!hold) begin
            vld <= 1'b1;
            a <= na[0];
            b <= nb[0];
            last <= nl == '0;
          end
        end
      end else if (!hold) begin
        vld <= 1'b1;
        a <= sa[idx];
        b <= sb[idx];
        last <= idx == len;
        idx <= idx + LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb_serial_operand_serializer: directed vectors for the operand serializer
module tb_serial_operand_serializer;
`ifdef SERIAL_TX_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif
  logic clk, rst, hold, vld, a, b, last, busy;
  serial_operand_serializer_if #(.WIDTH(8)) bus ();
  serial_operand_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hold(hold),
    .vld(vld), .a(a), .b(b), .last(last), .busy(busy)
  );
  int checks = 0, errors = 0;
  logic [31:0] cv, ca, cb, cl, cbz, crd;
  logic [7:0] qa[8], qb[8];
  logic [2:0] ql[8];
  int nq, qp;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] pa, input logic [7:0] pb, input logic [2:0] pl);
    qa[nq] = pa;
    qb[nq] = pb;
    ql[nq] = pl;
    nq++;
  endtask
  task automatic run(input int n, input logic [31:0] hm);
    logic x;
    {cv, ca, cb, cl, cbz, crd} = '0;
    for (int i = 0; i < n; i++) begin
      hold = hm[i];
      bus.in_vld = qp < nq;
      if (qp < nq) begin
        bus.in_a = qa[qp];
        bus.in_b = qb[qp];
        bus.in_len_m1 = ql[qp];
      end
      #1 x = bus.in_vld && bus.in_rdy;
      @(posedge clk);
      if (x) qp++;
      #1;
      cv[i] = vld;
      ca[i] = a;
      cb[i] = b;
      cl[i] = last;
      cbz[i] = busy;
      crd[i] = bus.in_rdy;
    end
    hold = 1'b0;
    bus.in_vld = 1'b0;
    nq = 0;
    qp = 0;
  endtask
  function automatic logic [31:0] pick(input logic [31:0] v, input logic [31:0] m);
    int k = 0;
    pick = '0;
    for (int i = 0; i < 32; i++) if (m[i]) begin
      pick[k] = v[i];
      k++;
    end
  endfunction
  function automatic int span(input logic [31:0] v);
    span = 0;
    for (int i = 0; i < 32; i++) if (v[i]) span = i + 1;
  endfunction
  initial begin
    logic c;
    logic [2:0] s;
    nq = 0;
    qp = 0;
    rst = 1'b1;
    hold = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_len_m1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {28'd0, vld, a, b, last}, 32'd0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", bus.in_rdy, 1);
    rst = 1'b0;
    push(8'hA5, 8'h3C, 3'd7);
    run(10, 0);
    chk("w8_vld", cv[9:0], 32'h0FF);
    chk("w8_a", ca[7:0], 32'hA5);
    chk("w8_b", cb[7:0], 32'h3C);
    chk("w8_last", cl[9:0], 32'h080);
    chk("w8_busy", cbz[9:0], 32'h0FF);
    chk("w8_rdy", {crd[8], crd[0]}, PF ? 32'd3 : 32'd2);
    push(8'hFF, 8'h01, 3'd2);
    run(4, 0);
    chk("w3_vld", cv[3:0], 32'h7);
    chk("w3_a", ca[2:0], 32'h7);
    chk("w3_b", cb[2:0], 32'h1);
    chk("w3_last", cl[3:0], 32'h4);
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s[i] = ca[i] ^ cb[i] ^ c;
      c = (ca[i] & cb[i]) | (c & (ca[i] ^ cb[i]));
    end
    chk("w3_sum", s, 0);
    push(8'h96, 8'h0F, 3'd7);
    run(11, 32'h44);
    chk("hold_vld", cv[10:0], 32'h3BB);
    chk("hold_a", pick(ca, cv), 32'h96);
    chk("hold_b", pick(cb, cv), 32'h0F);
    chk("hold_last", cl[10:0], 32'h200);
    push(8'h12, 8'h34, 3'd7);
    push(8'h56, 8'h78, 3'd7);
    run(18, 0);
    chk("two_vld", cv[17:0], PF ? 32'h0FFFF : 32'h1FEFF);
    chk("two_last", cl[17:0], PF ? 32'h08080 : 32'h10080);
    chk("two_a", pick(ca, cv), 32'h5612);
    chk("two_b", pick(cb, cv), 32'h7834);
    chk("two_span", span(cv), PF ? 16 : 17);
    chk("two_rdy1", crd[1], 0);
    push(8'hA5, 8'h3C, 3'd7);
    run(4, 0);
    chk("rst_pre", {cv[3:0], ca[3:0]}, 32'hF5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid", {29'd0, vld, last, busy}, 0);
    chk("rst_mid_rdy", bus.in_rdy, 1);
    rst = 1'b0;
    push(8'h3C, 8'hA5, 3'd3);
    run(5, 0);
    chk("post_vld", cv[4:0], 32'h0F);
    chk("post_a", ca[3:0], 32'hC);
    chk("post_b", cb[3:0], 32'h5);
    chk("post_last", cl[4:0], 32'h08);
    push(8'h01, 8'h00, 3'd0);
    push(8'h00, 8'h01, 3'd0);
    push(8'h01, 8'h00, 3'd0);
    push(8'h00, 8'h01, 3'd0);
    run(8, 0);
    chk("l1_vld", cv[7:0], PF ? 32'h0F : 32'h55);
    chk("l1_last", cl[7:0], PF ? 32'h0F : 32'h55);
    chk("l1_a", pick(ca, cv), 32'h5);
    chk("l1_b", pick(cb, cv), 32'hA);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_operand_serializer.md
# serial_operand_serializer

Parallel-to-serial front end for `serial_adder_with_vld`. It accepts operand pairs `A`/`B` with a bit length over a valid/ready handshake. It then drives the adder's `vld`/`a`/`b`/`last` stream LSB-first, one bit per clock, with optional bubbles inserted via `hold`.

## Interface
- `WIDTH`, default 8 — maximum operand width in bits; must be ≥ 2.
- `clk`  in  1 — single clock, all logic on posedge.
- `rst`  in  1 — synchronous, active-high reset.
- `in_vld`  in  1 — upstream word valid.
- `in_rdy`  out  1 — block can accept a word; combinational from state only, never from `in_vld`.
- `in_a`  in  WIDTH — operand A.
- `in_b`  in  WIDTH — operand B.
- `in_len_m1`  in  $clog2(WIDTH) — number of bits to send minus 1.
  - Range 0..WIDTH-1.
  - If the value is ≥ WIDTH, it is clamped to WIDTH-1.
- `hold`  in  1 — suppresses presentation of a new bit on the next cycle.
- `vld`  out  1 — serial bit valid; registered.
- `a`  out  1 — serial bit of A; registered.
- `b`  out  1 — serial bit of B; registered.
- `last`  out  1 — final bit of the current word; only ever high together with `vld`; registered.
- `busy`  out  1 — a word is in the shifter.

## Operation
- Handshake: a word transfers at a posedge where `in_vld && in_rdy`. `in_a`, `in_b` and `in_len_m1` are captured at that edge.
- State machine:
  - IDLE → SHIFT on transfer.
  - SHIFT → IDLE at the edge after the final bit is presented, when no queued word exists.
  - SHIFT → SHIFT, with the next word loaded, when a queued word exists. This path needs `SERIAL_TX_PREFETCH_EN`.
- Bit index `idx` counts 0..len_m1. Each present-edge drives:
  - `a <= A[idx]`, `b <= B[idx]`, `vld <= 1`
  - `last <= (idx == len_m1)`
  - `idx` then increments.
- The transfer edge is itself a present-edge for bit 0, unless `hold` is high.
- At every non-presenting edge, `vld`, `last`, `a` and `b` are driven to 0.
- A presented bit counts as consumed at the following edge, whatever `hold` is at that edge.
- `hold` high at an edge: no bit is presented and `idx` is frozen. Multiple consecutive holds are allowed.
- Operands are never modified. The carry belongs to the adder, and this block performs no arithmetic.
- `busy` is high from the transfer edge up to the edge at which the last bit is consumed.

## Timing
- Reset values:
  - `vld`, `a`, `b`, `last`, `busy` = 0.
  - `idx` = 0; prefetch buffer empty.
  - `in_rdy` = 1 in the first cycle after reset is released.
- Reset mid-word: the word in progress and any buffered word are discarded. Outputs are 0 in the next cycle and no `last` is emitted.
- Latency: a word accepted at edge T with no hold shows bit 0 in cycle T+, and bit i in cycle T+i.
  - `last` is shown in cycle T+len_m1.
  - Hold cycles add one cycle each.
- `len_m1 = 0`: a single cycle with `vld = last = 1`.
- Without prefetch:
  - `in_rdy = !busy`.
  - There is exactly one cycle with `vld = 0` between `last` and the next word's bit 0.
  - A word of L bits with no hold therefore occupies L+1 cycles.
- A transfer and the consumption of `last` can coincide at the same edge (prefetch only). The new word's bit 0 is presented at that same edge.

## Configuration
- `SERIAL_TX_PREFETCH_EN` defined:
  - Adds a one-word buffer (A, B, len_m1, full flag); `in_rdy = !buffer_full`.
  - A word accepted while in IDLE bypasses the buffer and goes straight to the shifter.
  - At the edge consuming `last`, a buffered word loads into the shifter and presents its bit 0, unless `hold` is high. This allows back-to-back streams with zero gap.
- Not defined: no buffer, `in_rdy = !busy`, and the one-cycle gap rule above applies.

## Test plan
- Single word, `WIDTH=8`, A=8'hA5, B=8'h3C, len_m1=7, hold=0 -> 8 consecutive cycles with `vld=1`:
  - `a` = 1,0,1,0,0,1,0,1
  - `b` = 0,0,1,1,1,1,0,0
  - `last` only on cycle 8
  - then `vld=0`, `busy=0`, `in_rdy=1`.
- Short word, A=8'hFF, B=8'h01, len_m1=2 -> `a`=1,1,1; `b`=1,0,0; `last` on the third bit. Cross-check through `serial_adder_with_vld`: sum bits 0,0,0.
- `hold` high at the edges after bits 1 and 4 of an 8-bit word -> exactly 2 `vld=0` bubbles; bit order is unchanged and `last` still marks bit 7.
- Two words offered continuously (A=8'h12/B=8'h34, then A=8'h56/B=8'h78, len_m1=7):
  - Without macro: gap of 1 idle cycle and 17 cycles in total.
  - With `SERIAL_TX_PREFETCH_EN`: bit 0 of word 2 follows `last` directly, 16 cycles, and `in_rdy` drops while the buffer is full.
- `rst` asserted during bit 3 -> next cycle `vld=last=busy=0` and `in_rdy=1`. A new word sent afterwards streams correctly from bit 0.
- `len_m1=0` words back-to-back with prefetch -> `vld=last=1` every cycle, alternating operand bit 0.
